// File: rtl/drain_collector_pkg.sv
// drain_collector_pkg: shared types for the column drain collector.
package drain_collector_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DIM = 4;
    localparam int RESULT_WIDTH = DIM * DATA_WIDTH;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef struct packed {
        logic  enable;
        data_t data;
    } drain_data_t;
    typedef data_t [DIM-1:0] result_word_t;
    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} collector_state_t;
endpackage

// File: rtl/drain_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter; push while full succeeds only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/drain_collector.sv
// drain_collector: packs DIM drained beats of one column into a result word and queues it for the writer.
module drain_collector
    import drain_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  drain_data_t             drain_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [RESULT_WIDTH-1:0] res_data_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic                    error_o
);
    localparam int CW = $clog2(DIM + 1);
    localparam int IW = $clog2(DIM);
    collector_state_t state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    result_word_t pack;
    logic full, empty;
    // bottom row drains first, so the k-th beat lands in element DIM-1-k
    assign idx = IW'(DIM - 1) - cnt[IW-1:0];
    assign res_valid_o = !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pack    <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            error_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= COLLECT;
                        cnt     <= '0;
                        error_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end else if (drain_i.enable) error_o <= 1'b1;
                end
                COLLECT: begin
                    if (start_i) cnt <= '0;
                    else if (drain_i.enable) begin
                        pack[idx] <= drain_i.data;
                        cnt       <= cnt + 1'b1;
                        if (cnt == CW'(DIM - 1)) begin
                            state  <= PUSH;
                            done_o <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    state  <= start_i ? COLLECT : IDLE;
                    busy_o <= start_i;
                    cnt    <= '0;
                    if (drain_i.enable || (full && !res_ready_i)) error_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    sync_fifo #(.WIDTH(RESULT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == PUSH),
        .pop   (res_ready_i),
        .wdata (pack),
        .rdata (res_data_o),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_drain_collector.sv
// tb_drain_collector: directed checks of packing, holes, backpressure, restart and reset.
module tb_drain_collector;
    import drain_collector_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic res_ready_i = 1'b0;
    drain_data_t drain_i = '0;
    logic res_valid_o, done_o, busy_o, error_o;
    logic [RESULT_WIDTH-1:0] res_data_o;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] exp_q [$];

    drain_collector #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .drain_i     (drain_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done_o) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic en);
        drain_i = '{enable: en, data: d};
        tick;
        drain_i = '0;
    endtask

    task automatic start_pulse;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    task automatic collect(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) beat(w[i*8 +: 8], 1'b1);
    endtask

    task automatic send(input logic [31:0] w);
        start_pulse;
        collect(w);
        tick;
    endtask

    task automatic drain_all(input string tag);
        res_ready_i = 1'b1;
        while (exp_q.size() > 0) begin
            check({tag, "_valid"}, 32'(res_valid_o), 32'd1);
            check({tag, "_data"}, res_data_o, exp_q.pop_front());
            tick;
        end
        res_ready_i = 1'b0;
        check({tag, "_empty"}, 32'(res_valid_o), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        rst_n = 1'b1;
        tick;

        // basic: latency, done pulse, packing order
        res_ready_i = 1'b1;
        start_pulse;
        check("basic_busy", 32'(busy_o), 32'd1);
        collect(32'h11223344);
        check("basic_done", 32'(done_o), 32'd1);
        check("basic_valid_early", 32'(res_valid_o), 32'd0);
        tick;
        check("basic_done_end", 32'(done_o), 32'd0);
        check("basic_valid", 32'(res_valid_o), 32'd1);
        check("basic_data", res_data_o, 32'h11223344);
        check("basic_idle", 32'(busy_o), 32'd0);
        tick;
        check("basic_popped", 32'(res_valid_o), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_error", 32'(error_o), 32'd0);
        res_ready_i = 1'b0;

        // holes interleaved
        start_pulse;
        beat(8'h11, 1'b1);
        beat(8'hEE, 1'b0);
        beat(8'hEE, 1'b0);
        beat(8'h22, 1'b1);
        beat(8'h33, 1'b1);
        beat(8'hEE, 1'b0);
        beat(8'h44, 1'b1);
        tick;
        exp_q.push_back(32'h11223344);
        drain_all("holes");
        check("holes_done_cnt", 32'(done_cnt), 32'd2);

        // overflow under backpressure
        send(32'h01020304);
        send(32'h05060708);
        send(32'h090A0B0C);
        send(32'h0D0E0F10);
        check("ovf_err_before", 32'(error_o), 32'd0);
        send(32'h11121314);
        check("ovf_err_after", 32'(error_o), 32'd1);
        check("ovf_done_cnt", 32'(done_cnt), 32'd7);
        exp_q = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        drain_all("ovf");
        check("ovf_err_sticky", 32'(error_o), 32'd1);

        // full with simultaneous pop
        send(32'hA0A1A2A3);
        check("fullpop_err_cleared", 32'(error_o), 32'd0);
        send(32'hB0B1B2B3);
        send(32'hC0C1C2C3);
        send(32'hD0D1D2D3);
        start_pulse;
        collect(32'hE0E1E2E3);
        res_ready_i = 1'b1;
        tick;
        res_ready_i = 1'b0;
        check("fullpop_err", 32'(error_o), 32'd0);
        exp_q = '{32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
        drain_all("fullpop");

        // restart mid-collection, then stray beat in IDLE
        start_pulse;
        beat(8'hB1, 1'b1);
        beat(8'hB2, 1'b1);
        start_pulse;
        check("restart_busy", 32'(busy_o), 32'd1);
        collect(32'hA1A2A3A4);
        tick;
        check("restart_err", 32'(error_o), 32'd0);
        exp_q.push_back(32'hA1A2A3A4);
        drain_all("restart");
        beat(8'h55, 1'b1);
        check("stray_err", 32'(error_o), 32'd1);
        start_pulse;
        check("stray_cleared", 32'(error_o), 32'd0);

        // two words queued, start+stray during PUSH, then reset mid-collection
        collect(32'h31323334);
        tick;
        start_pulse;
        collect(32'h41424344);
        start_i = 1'b1;
        drain_i = '{enable: 1'b1, data: 8'h99};
        tick;
        start_i = 1'b0;
        drain_i = '0;
        check("pushstart_err", 32'(error_o), 32'd1);
        check("pushstart_busy", 32'(busy_o), 32'd1);
        beat(8'h61, 1'b1);
        beat(8'h62, 1'b1);
        beat(8'h63, 1'b1);
        check("prerst_valid", 32'(res_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(res_valid_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_error", 32'(error_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        send(32'hC1C2C3C4);
        exp_q.push_back(32'hC1C2C3C4);
        drain_all("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
